// File: rtl/nios2_jtag_cmd_bridge.sv
// nios2_jtag_cmd_bridge
// System-clock side of the debug JTAG path. It synchronises the TCK-domain
// update-IR / update-DR levels and captures {IR, SR} on each update-DR. The
// captured commands are queued, and popping the queue head issues a one-cycle
// take_action or take_no_action strobe on the head's IR channel. The popped
// data register is presented on jdo.

// Per-signal synchroniser: STAGES flops, then a history flop for rise detection.
module nios2_jtag_cmd_bridge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Shift the asynchronous level in and keep one cycle of history.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

module nios2_jtag_cmd_bridge #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACT_BIT     = 34
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            vs_uir,
    input  logic                            vs_udr,
    input  logic [IR_WIDTH-1:0]             ir_in,
    input  logic [SR_WIDTH-1:0]             sr,
    input  logic                            cmd_ready,
    input  logic                            ovf_clr,
    output logic                            cmd_valid,
    output logic [IR_WIDTH-1:0]             cmd_ir,
    output logic [SR_WIDTH-1:0]             jdo,
    output logic [(2**IR_WIDTH)-1:0]        take_action,
    output logic [(2**IR_WIDTH)-1:0]        take_no_action,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            ovf
);

    localparam int NCH      = 2**IR_WIDTH;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int ARM_DONE = SYNC_STAGES + 1;
    localparam int ARM_W    = $clog2(ARM_DONE + 1);

    typedef struct packed {
        logic [IR_WIDTH-1:0] ir;
        logic [SR_WIDTH-1:0] sr;
    } cmd_t;

    // ------------------------------------------------------------------
    // TCK-domain level synchronisation (lane 0 = update-IR, lane 1 = update-DR)
    // ------------------------------------------------------------------
    logic [1:0] tck_lvl;
    logic [1:0] tck_rise;

    assign tck_lvl = {vs_udr, vs_uir};

    for (genvar g = 0; g < 2; g++) begin : g_sync
        nios2_jtag_cmd_bridge_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .reset_n  (reset_n),
            .async_in (tck_lvl[g]),
            .rise     (tck_rise[g])
        );
    end

    // ------------------------------------------------------------------
    // Arm window: the synchroniser needs SYNC_STAGES+1 cycles to reflect an
    // input that was already high at reset release. Rises seen before that
    // are start-up artefacts and must not fire.
    // ------------------------------------------------------------------
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;

    assign armed = (arm_cnt == ARM_W'(ARM_DONE));

    // Saturating count of cycles since reset release.
    always_ff @(posedge clk) begin
        if (!reset_n)
            arm_cnt <= '0;
        else if (!armed)
            arm_cnt <= arm_cnt + ARM_W'(1);
    end

    logic uir_ev;
    logic udr_ev;

    assign uir_ev = tck_rise[0] & armed;
    assign udr_ev = tck_rise[1] & armed;

    // ------------------------------------------------------------------
    // IR latch and capture stage. The capture stage registers {ir_latch, sr}
    // in the edge-detect cycle, so a coincident UIR edge still pairs the
    // data with the previous IR.
    // ------------------------------------------------------------------
    logic [IR_WIDTH-1:0] ir_latch;
    logic                push_vld;
    cmd_t                push_cmd;

    // Track the most recent virtual IR.
    always_ff @(posedge clk) begin
        if (!reset_n)
            ir_latch <= '0;
        else if (uir_ev)
            ir_latch <= ir_in;
    end

    // Capture the command on an armed update-DR rise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            push_vld <= 1'b0;
            push_cmd <= '0;
        end else begin
            push_vld <= udr_ev;
            if (udr_ev)
                push_cmd <= '{ir: ir_latch, sr: sr};
        end
    end

    // ------------------------------------------------------------------
    // Command queue: circular buffer with free-running wrap-around pointers
    // (FIFO_DEPTH is a power of two).
    // ------------------------------------------------------------------
    cmd_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    cmd_t             head;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    assign head      = mem[rd_ptr];
    assign full      = (count == LVL_W'(FIFO_DEPTH));
    assign cmd_valid = (count != '0);
    assign cmd_ir    = head.ir;
    assign fifo_level = count;

    // A simultaneous pop frees a slot, so a push into a full queue survives.
    assign pop     = cmd_valid & cmd_ready;
    assign push_ok = push_vld & (~full | pop);
    assign drop    = push_vld & full & ~pop;

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_cmd;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pop side: registered jdo plus one-cycle per-IR strobes.
    // ------------------------------------------------------------------
    logic [NCH-1:0] ir_onehot;

    assign ir_onehot = NCH'(1) << head.ir;

    // Issue the strobe for the popped command; jdo holds between pops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (pop) begin
                jdo <= head.sr;
                if (head.sr[ACT_BIT])
                    take_action <= ir_onehot;
                else
                    take_no_action <= ir_onehot;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (!reset_n)
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

endmodule

// File: tb/tb_nios2_jtag_cmd_bridge.sv
// Bench for nios2_jtag_cmd_bridge: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model built from delayed input samples and a command queue.
module tb_nios2_jtag_cmd_bridge;

    localparam int SRW  = 38;
    localparam int IRW  = 2;
    localparam int S    = 2;
    localparam int D    = 4;
    localparam int ACT  = 34;
    localparam int NCH  = 4;
    localparam int LW   = 3;
    localparam int MAXC = 16384;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            vs_uir = 1'b0;
    logic            vs_udr = 1'b0;
    logic [IRW-1:0]  ir_in = '0;
    logic [SRW-1:0]  sr = '0;
    logic            cmd_ready = 1'b0;
    logic            ovf_clr = 1'b0;
    logic            cmd_valid;
    logic [IRW-1:0]  cmd_ir;
    logic [SRW-1:0]  jdo;
    logic [NCH-1:0]  take_action;
    logic [NCH-1:0]  take_no_action;
    logic [LW-1:0]   fifo_level;
    logic            ovf;

    always #5 clk = ~clk;

    nios2_jtag_cmd_bridge #(
        .SR_WIDTH(SRW), .IR_WIDTH(IRW), .SYNC_STAGES(S), .FIFO_DEPTH(D), .ACT_BIT(ACT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
        .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .jdo(jdo),
        .take_action(take_action), .take_no_action(take_no_action),
        .fifo_level(fifo_level), .ovf(ovf)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. A TCK level sampled at edge j becomes visible to
    // the bridge as a rise whose detect cycle ends at edge j+S; the command
    // captured there joins the queue one edge later. Samples at or before
    // the last reset edge count as 0, and rises are ignored until S+1
    // edges have passed since reset release.
    // ------------------------------------------------------------------
    typedef struct {
        logic [IRW-1:0] ir;
        logic [SRW-1:0] sr;
    } ent_t;

    ent_t           mq[$];
    int             cyc = 0;
    int             last_rst = 0;
    bit             us [MAXC];
    bit             ds [MAXC];
    logic [IRW-1:0] m_ir = '0;
    bit             m_pend = 1'b0;
    ent_t           m_pcmd;
    logic [SRW-1:0] m_jdo = '0;
    logic [NCH-1:0] m_ta = '0;
    logic [NCH-1:0] m_tna = '0;
    bit             m_ovf = 1'b0;

    function automatic bit eff(input int j, input bit is_udr);
        if (j <= last_rst || j < 0) return 1'b0;
        return is_udr ? ds[j] : us[j];
    endfunction

    function automatic bit rise_at(input int k, input bit is_udr);
        return eff(k - S, is_udr) && !eff(k - S - 1, is_udr);
    endfunction

    always @(posedge clk) begin
        ent_t h;
        bit   pop;
        bit   armed;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL model_capacity: got cycle %0d expected below %0d", cyc, MAXC);
            $fatal(1, "model history exhausted");
        end
        if (!reset_n) begin
            last_rst = cyc;
            us[cyc] = 1'b0;
            ds[cyc] = 1'b0;
            mq.delete();
            m_ir = '0; m_pend = 1'b0; m_jdo = '0;
            m_ta = '0; m_tna = '0; m_ovf = 1'b0;
        end else begin
            us[cyc] = vs_uir;
            ds[cyc] = vs_udr;
            m_ta = '0;
            m_tna = '0;
            pop = (mq.size() != 0) && cmd_ready;
            if (pop) begin
                h = mq.pop_front();
                m_jdo = h.sr;
                if (h.sr[ACT]) m_ta[h.ir] = 1'b1;
                else           m_tna[h.ir] = 1'b1;
            end
            if (m_pend) begin
                if (mq.size() < D) mq.push_back(m_pcmd);
                else               m_ovf = 1'b1;
            end else if (ovf_clr) begin
                m_ovf = 1'b0;
            end
            if (m_pend && mq.size() < D) begin
                // pushed above; ovf_clr still applies when nothing was dropped
                if (ovf_clr) m_ovf = 1'b0;
            end
            armed  = (cyc - 1 - last_rst) >= S + 1;
            m_pend = armed && rise_at(cyc, 1'b1);
            if (m_pend) begin
                m_pcmd.ir = m_ir;
                m_pcmd.sr = sr;
            end
            if (armed && rise_at(cyc, 1'b0)) m_ir = ir_in;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("cmd_valid", cmd_valid, mq.size() != 0);
            chk("fifo_level", fifo_level, mq.size());
            if (mq.size() != 0) chk("cmd_ir", cmd_ir, mq[0].ir);
            chk("jdo", jdo, m_jdo);
            chk("take_action", take_action, m_ta);
            chk("take_no_action", take_no_action, m_tna);
            chk("ovf", ovf, m_ovf);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic uir_pulse(input logic [IRW-1:0] v);
        ir_in = v;
        vs_uir = 1'b1;
        tick(3);
        vs_uir = 1'b0;
        tick(3);
    endtask

    task automatic udr_pulse(input logic [SRW-1:0] v);
        sr = v;
        vs_udr = 1'b1;
        tick(3);
        vs_udr = 1'b0;
        tick(3);
    endtask

    // Raise vs_udr and return how many falling edges pass until cmd_valid.
    task automatic udr_rise_latency(input logic [SRW-1:0] v, output int lat);
        sr = v;
        vs_udr = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (cmd_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // Reset with vs_udr already high: nothing fires after release.
        reset_n = 1'b0;
        vs_udr  = 1'b1;
        sr      = 38'h3F_FFFF_FFFF;
        tick(3);
        chk("rst_level", fifo_level, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_jdo", jdo, 0);
        chk("rst_ovf", ovf, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("arm_level", fifo_level, 0);
            chk("arm_strobe", take_action | take_no_action, 0);
        end
        vs_udr = 1'b0;
        tick(4);

        // IR 1, action bit set.
        cmd_ready = 1'b1;
        uir_pulse(2'b01);
        udr_rise_latency(38'h04_0000_1234, lat);
        chk("udr_latency", lat, 4);
        tick(1);
        chk("act_jdo", jdo, 38'h04_0000_1234);
        chk("act_strobe", take_action, 4'b0010);
        chk("act_no_strobe", take_no_action, 4'b0000);
        tick(1);
        chk("act_once", take_action, 4'b0000);
        vs_udr = 1'b0;
        tick(4);

        // IR 3, action bit clear.
        uir_pulse(2'b11);
        udr_rise_latency(38'h00_DEAD_BEEF, lat);
        chk("udr_latency2", lat, 4);
        tick(1);
        chk("noact_strobe", take_no_action, 4'b1000);
        chk("noact_act", take_action, 4'b0000);
        vs_udr = 1'b0;
        tick(1);
        chk("noact_once", take_no_action, 4'b0000);
        tick(5);
        chk("noact_jdo_hold", jdo[31:0], 32'hDEAD_BEEF);

        // Overflow: five pushes into four slots.
        cmd_ready = 1'b0;
        for (int v = 1; v <= 5; v++) udr_pulse(SRW'(v));
        tick(4);
        chk("ovf_level", fifo_level, 4);
        chk("ovf_set", ovf, 1);
        cmd_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            tick(1);
            chk("drain_jdo", jdo, v);
            chk("drain_strobe", take_no_action, 4'b1000);
        end
        tick(1);
        chk("drain_idle", take_action | take_no_action, 0);
        chk("ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // Full queue with a push coinciding with a pop.
        cmd_ready = 1'b0;
        for (int v = 11; v <= 14; v++) udr_pulse(SRW'(v));
        tick(2);
        chk("full_level", fifo_level, 4);
        sr = SRW'(15);
        vs_udr = 1'b1;
        tick(3);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("overlap_level", fifo_level, 4);
        chk("overlap_ovf", ovf, 0);
        chk("overlap_jdo", jdo, 11);
        vs_udr = 1'b0;
        tick(3);
        cmd_ready = 1'b1;
        for (int v = 12; v <= 15; v++) begin
            tick(1);
            chk("overlap_drain", jdo, v);
        end
        cmd_ready = 1'b0;
        tick(2);

        // Reset with three entries queued.
        for (int v = 21; v <= 23; v++) udr_pulse(SRW'(v));
        tick(2);
        chk("pre_rst_level", fifo_level, 3);
        reset_n = 1'b0;
        tick(1);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_valid", cmd_valid, 0);
        chk("midrst_jdo", jdo, 0);
        chk("midrst_ovf", ovf, 0);
        tick(1);
        reset_n = 1'b1;
        cmd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("post_rst_strobe", take_action | take_no_action, 0);
        end

        // Randomized traffic; the first half backs up the queue.
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if ($urandom_range(0, 7) == 0) vs_uir = ~vs_uir;
            if ($urandom_range(0, 4) == 0) vs_udr = ~vs_udr;
            ir_in     = IRW'($urandom());
            sr        = SRW'({$urandom(), $urandom()});
            cmd_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            reset_n   = ($urandom_range(0, 299) != 0);
        end
        reset_n = 1'b1;
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        ovf_clr = 1'b0;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
